// File: rtl/cx_switch_pkg.sv
// Shared definitions for the out-of-order-capable CX switch.
// Contents:
//   ST_*           response status codes returned to the host
//   CX_ID_MAX_W    widest CXU id the order entry can carry
//   order_entry_t  one outstanding request: {err, id}
//   clog2          ceil(log2(n)), never less than 1, for counter widths
package cx_switch_pkg;

  localparam logic [3:0] ST_OK      = 4'h0;
  localparam logic [3:0] ST_BAD_ID  = 4'h1;
  localparam logic [3:0] ST_TIMEOUT = 4'h2;

  // The id field is sized for the widest supported ID_W; narrower ids
  // are zero-extended on push.
  localparam int CX_ID_MAX_W = 8;

  typedef struct packed {
    logic                   err;
    logic [CX_ID_MAX_W-1:0] id;
  } order_entry_t;

  // Returns at least 1 so that degenerate sizes still give a legal vector.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cx_order_fifo.sv
// Synchronous FIFO holding the order of outstanding CX requests.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   push, push_data write one entry (caller guarantees not full unless popping)
//   pop             remove the head entry (caller guarantees not empty)
//   full, empty     occupancy flags
//   head            current head entry, valid while !empty
// Push and pop in the same cycle are allowed at any occupancy.
module cx_order_fifo
  import cx_switch_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says so.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cx_switch_ooo.sv
// CX switch: routes requests from the Ibex CX port to N_CXU extension units,
// keeps up to DEPTH requests outstanding and returns responses in request
// order. Invalid CXU ids get a synthesised ST_BAD_ID response, and a head
// request that waits TIMEOUT cycles gets ST_TIMEOUT (TIMEOUT = 0 disables).
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   cx_req_*                 host request (valid/ready, id, state, operands)
//   cx_resp_*                host response, registered (valid/ready, status, data)
//   cxu_req_valid/ready      one-hot request handshake toward the CXUs
//   cxu_state_id, cxu_data*  request payload broadcast to all CXUs
//   cxu_resp_*               per-CXU response handshake, packed data/status
module cx_switch_ooo
  import cx_switch_pkg::*;
#(
  parameter int N_CXU   = 4,
  parameter int ID_W    = 3,
  parameter int STATE_W = 2,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cx_req_valid,
  output logic                  cx_req_ready,
  input  logic [ID_W-1:0]       cx_cxu_id,
  input  logic [STATE_W-1:0]    cx_state_id,
  input  logic [XLEN-1:0]       cx_req_data0,
  input  logic [XLEN-1:0]       cx_req_data1,
  output logic                  cx_resp_valid,
  input  logic                  cx_resp_ready,
  output logic [3:0]            cx_resp_status,
  output logic [XLEN-1:0]       cx_resp_data,
  output logic [N_CXU-1:0]      cxu_req_valid,
  input  logic [N_CXU-1:0]      cxu_req_ready,
  output logic [STATE_W-1:0]    cxu_state_id,
  output logic [XLEN-1:0]       cxu_data0,
  output logic [XLEN-1:0]       cxu_data1,
  input  logic [N_CXU-1:0]      cxu_resp_valid,
  output logic [N_CXU-1:0]      cxu_resp_ready,
  input  logic [N_CXU*XLEN-1:0] cxu_resp_data,
  input  logic [N_CXU*4-1:0]    cxu_resp_status
);

  localparam int DCW = clog2(DEPTH + 1);
  localparam int TW  = clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  logic            vid, tgt_ready, accept, full, empty;
  order_entry_t    push_ent, head_ent;
  logic            head_rv, head_drop_zero;
  logic [3:0]      head_st;
  logic [XLEN-1:0] head_data;
  logic            ev_err, ev_resp, ev_to, load;

  logic            resp_valid_q, resp_valid_d;
  logic [3:0]      resp_status_q, resp_status_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DCW-1:0]  drop_cnt_q [N_CXU];
  logic [DCW-1:0]  drop_cnt_d [N_CXU];

  // ---------------- request path ----------------
  assign cxu_state_id = cx_state_id;
  assign cxu_data0    = cx_req_data0;
  assign cxu_data1    = cx_req_data1;

  always_comb begin
    vid       = (32'(cx_cxu_id) < N_CXU);
    // Invalid ids match no CXU and are accepted without a target handshake.
    tgt_ready = 1'b1;
    for (int i = 0; i < N_CXU; i++) begin
      if (cx_cxu_id == ID_W'(i)) tgt_ready = cxu_req_ready[i];
    end
    cx_req_ready = !full && tgt_ready;
    accept       = cx_req_valid && cx_req_ready;
    push_ent.err = !vid;
    push_ent.id  = CX_ID_MAX_W'(cx_cxu_id);
  end

  generate
    for (genvar gi = 0; gi < N_CXU; gi++) begin : g_req
      assign cxu_req_valid[gi] = cx_req_valid && !full && vid && (cx_cxu_id == ID_W'(gi));
    end
  endgenerate

  cx_order_fifo #(
    .WIDTH ($bits(order_entry_t)),
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_ent),
    .pop       (load),
    .full      (full),
    .empty     (empty),
    .head      (head_ent)
  );

  // ---------------- head resolution ----------------
  always_comb begin
    head_rv        = 1'b0;
    head_drop_zero = 1'b0;
    head_st        = '0;
    head_data      = '0;
    for (int i = 0; i < N_CXU; i++) begin
      if (head_ent.id == CX_ID_MAX_W'(i)) begin
        head_rv        = cxu_resp_valid[i];
        head_drop_zero = (drop_cnt_q[i] == '0);
        head_st        = cxu_resp_status[i*4 +: 4];
        head_data      = cxu_resp_data[i*XLEN +: XLEN];
      end
    end
    // A CXU with pending drops still owes responses to timed-out requests,
    // so its next response cannot belong to the current head.
    ev_err  = !empty && head_ent.err;
    ev_resp = !empty && !head_ent.err && head_drop_zero && head_rv;
    ev_to   = !empty && !head_ent.err && !ev_resp && (TIMEOUT != 0) && (timer_q == T_LAST);
    load    = (ev_err || ev_resp || ev_to) && (!resp_valid_q || cx_resp_ready);
  end

  generate
    for (genvar gi = 0; gi < N_CXU; gi++) begin : g_resp_ready
      assign cxu_resp_ready[gi] = (drop_cnt_q[gi] != '0) ||
                                  (load && ev_resp && (head_ent.id == CX_ID_MAX_W'(gi)));
    end
  endgenerate

  // ---------------- next state ----------------
  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_status_d = resp_status_q;
    resp_data_d   = resp_data_q;
    if (load) begin
      resp_valid_d = 1'b1;
      if (ev_err) begin
        resp_status_d = ST_BAD_ID;
        resp_data_d   = '0;
      end else if (ev_resp) begin
        resp_status_d = head_st;
        resp_data_d   = head_data;
      end else begin
        resp_status_d = ST_TIMEOUT;
        resp_data_d   = '0;
      end
    end else if (cx_resp_ready) begin
      resp_valid_d = 1'b0;
    end

    // The timer parks on its last value while a timeout is blocked by host
    // backpressure, so the timeout event is not lost.
    if (empty || load) begin
      timer_d = '0;
    end else if ((TIMEOUT != 0) && (timer_q != T_LAST)) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end

    for (int i = 0; i < N_CXU; i++) begin
      drop_cnt_d[i] = drop_cnt_q[i];
      if (load && ev_to && (head_ent.id == CX_ID_MAX_W'(i)) &&
          !((drop_cnt_q[i] != '0) && cxu_resp_valid[i])) begin
        if (drop_cnt_q[i] != DCW'(DEPTH)) drop_cnt_d[i] = drop_cnt_q[i] + DCW'(1);
      end else if ((drop_cnt_q[i] != '0) && cxu_resp_valid[i] &&
                   !(load && ev_to && (head_ent.id == CX_ID_MAX_W'(i)))) begin
        drop_cnt_d[i] = drop_cnt_q[i] - DCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
      resp_data_q   <= '0;
      timer_q       <= '0;
      for (int i = 0; i < N_CXU; i++) drop_cnt_q[i] <= '0;
    end else begin
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      resp_data_q   <= resp_data_d;
      timer_q       <= timer_d;
      for (int i = 0; i < N_CXU; i++) drop_cnt_q[i] <= drop_cnt_d[i];
    end
  end

  assign cx_resp_valid  = resp_valid_q;
  assign cx_resp_status = resp_status_q;
  assign cx_resp_data   = resp_data_q;

endmodule

// File: tb/tb_cx_switch_ooo.sv
// Directed bench for cx_switch_ooo with N_CXU=3, ID_W=2, DEPTH=4, TIMEOUT=16.
module tb_cx_switch_ooo;

  localparam int N  = 3;
  localparam int IW = 2;
  localparam int SW = 2;
  localparam int XL = 32;
  localparam int DP = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cx_req_valid;
  logic            cx_req_ready;
  logic [IW-1:0]   cx_cxu_id;
  logic [SW-1:0]   cx_state_id;
  logic [XL-1:0]   cx_req_data0, cx_req_data1;
  logic            cx_resp_valid;
  logic            cx_resp_ready;
  logic [3:0]      cx_resp_status;
  logic [XL-1:0]   cx_resp_data;
  logic [N-1:0]    cxu_req_valid;
  logic [N-1:0]    cxu_req_ready;
  logic [SW-1:0]   cxu_state_id;
  logic [XL-1:0]   cxu_data0, cxu_data1;
  logic [N-1:0]    cxu_resp_valid;
  logic [N-1:0]    cxu_resp_ready;
  logic [N*XL-1:0] cxu_resp_data;
  logic [N*4-1:0]  cxu_resp_status;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cx_switch_ooo #(
    .N_CXU(N), .ID_W(IW), .STATE_W(SW), .XLEN(XL), .DEPTH(DP), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cx_req_valid(cx_req_valid), .cx_req_ready(cx_req_ready),
    .cx_cxu_id(cx_cxu_id), .cx_state_id(cx_state_id),
    .cx_req_data0(cx_req_data0), .cx_req_data1(cx_req_data1),
    .cx_resp_valid(cx_resp_valid), .cx_resp_ready(cx_resp_ready),
    .cx_resp_status(cx_resp_status), .cx_resp_data(cx_resp_data),
    .cxu_req_valid(cxu_req_valid), .cxu_req_ready(cxu_req_ready),
    .cxu_state_id(cxu_state_id), .cxu_data0(cxu_data0), .cxu_data1(cxu_data1),
    .cxu_resp_valid(cxu_resp_valid), .cxu_resp_ready(cxu_resp_ready),
    .cxu_resp_data(cxu_resp_data), .cxu_resp_status(cxu_resp_status)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic          v;
    logic [N-1:0]  rdy;
    logic [XL-1:0] d0;
    logic          exp_ready;
    logic [N-1:0]  exp_cxu_valid;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic req(input logic [IW-1:0] id);
    cx_req_valid = 1'b1;
    cx_cxu_id    = id;
  endtask

  task automatic cxu_resp(input int i, input logic [XL-1:0] d, input logic [3:0] s);
    cxu_resp_valid[i]           = 1'b1;
    cxu_resp_data[i*XL +: XL]   = d;
    cxu_resp_status[i*4 +: 4]   = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    vecs[0] = '{2'd0, 1'b1, 3'b111, 32'h0000_0011, 1'b1, 3'b001};
    vecs[1] = '{2'd1, 1'b1, 3'b111, 32'h0000_0022, 1'b1, 3'b010};
    vecs[2] = '{2'd2, 1'b1, 3'b011, 32'h0000_0033, 1'b0, 3'b100};
    vecs[3] = '{2'd3, 1'b1, 3'b000, 32'h0000_0044, 1'b1, 3'b000};
    vecs[4] = '{2'd1, 1'b0, 3'b111, 32'h0000_0055, 1'b1, 3'b000};
    vecs[5] = '{2'd0, 1'b1, 3'b110, 32'h0000_0066, 1'b0, 3'b001};

    rst             = 1'b0;
    cx_req_valid    = 1'b0;
    cx_cxu_id       = '0;
    cx_state_id     = '0;
    cx_req_data0    = '0;
    cx_req_data1    = '0;
    cx_resp_ready   = 1'b1;
    cxu_req_ready   = 3'b111;
    cxu_resp_valid  = '0;
    cxu_resp_data   = '0;
    cxu_resp_status = '0;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_resp_valid", cx_resp_valid, 0);
    chk("rst_resp_status", cx_resp_status, 0);
    chk("rst_resp_data", cx_resp_data, 0);
    rst = 1'b1;
    tick();

    // ---- request path table with an empty FIFO (no clock edge in between) ----
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cx_cxu_id     = vecs[k].id;
      cx_req_valid  = vecs[k].v;
      cxu_req_ready = vecs[k].rdy;
      cx_req_data0  = vecs[k].d0;
      cx_state_id   = 2'd2;
      #1;
      chk($sformatf("tbl%0d_req_ready", k), cx_req_ready, vecs[k].exp_ready);
      chk($sformatf("tbl%0d_cxu_req_valid", k), cxu_req_valid, vecs[k].exp_cxu_valid);
      chk($sformatf("tbl%0d_data0", k), cxu_data0, vecs[k].d0);
      cx_req_valid  = 1'b0;
      cxu_req_ready = 3'b111;
    end
    chk("tbl_state_id", cxu_state_id, 2);
    tick();

    // ---- single request, one-cycle response latency ----
    req(2'd1);
    cx_req_data0 = 32'h5;
    #1;
    chk("t1_cxu_req_valid", cxu_req_valid, 3'b010);
    chk("t1_req_ready", cx_req_ready, 1);
    tick();
    cx_req_valid = 1'b0;
    cxu_resp(1, 32'h1234, 4'h0);
    #1;
    chk("t1_cxu_resp_ready", cxu_resp_ready, 3'b010);
    chk("t1_not_yet", cx_resp_valid, 0);
    tick();
    cxu_resp_valid = '0;
    #1;
    chk("t1_resp_valid", cx_resp_valid, 1);
    chk("t1_resp_data", cx_resp_data, 32'h1234);
    chk("t1_resp_status", cx_resp_status, 0);
    tick();
    chk("t1_resp_done", cx_resp_valid, 0);

    // ---- ordering: CXU2 then CXU0, CXU0 answers first ----
    req(2'd2);
    tick();
    req(2'd0);
    tick();
    cx_req_valid = 1'b0;
    cxu_resp(0, 32'hAAAA, 4'h0);
    #1;
    chk("t2_c0_blocked", cxu_resp_ready, 3'b000);
    tick();
    chk("t2_c0_still_blocked", cxu_resp_ready, 3'b000);
    chk("t2_no_resp", cx_resp_valid, 0);
    cxu_resp(2, 32'hBBBB, 4'h0);
    #1;
    chk("t2_c2_taken", cxu_resp_ready, 3'b100);
    tick();
    cxu_resp_valid[2] = 1'b0;
    #1;
    chk("t2_first_valid", cx_resp_valid, 1);
    chk("t2_first_data", cx_resp_data, 32'hBBBB);
    chk("t2_c0_taken", cxu_resp_ready, 3'b001);
    tick();
    cxu_resp_valid = '0;
    #1;
    chk("t2_second_valid", cx_resp_valid, 1);
    chk("t2_second_data", cx_resp_data, 32'hAAAA);
    tick();
    chk("t2_done", cx_resp_valid, 0);

    // ---- invalid id: response two cycles after acceptance ----
    req(2'd3);
    #1;
    chk("t3_no_cxu_valid", cxu_req_valid, 3'b000);
    chk("t3_req_ready", cx_req_ready, 1);
    tick();
    cx_req_valid = 1'b0;
    #1;
    chk("t3_t1_no_resp", cx_resp_valid, 0);
    tick();
    chk("t3_resp_valid", cx_resp_valid, 1);
    chk("t3_resp_status", cx_resp_status, 4'h1);
    chk("t3_resp_data", cx_resp_data, 0);
    tick();
    chk("t3_done", cx_resp_valid, 0);

    // ---- full FIFO ----
    for (int k = 0; k < 4; k++) begin
      req(2'd1);
      tick();
    end
    #1;
    chk("t4_full_ready", cx_req_ready, 0);
    chk("t4_full_no_cxu_valid", cxu_req_valid, 3'b000);
    cxu_resp(1, 32'h40, 4'h0);
    #1;
    chk("t4_pop_resp_ready", cxu_resp_ready, 3'b010);
    chk("t4_pop_cycle_ready", cx_req_ready, 0);
    tick();
    chk("t4_count3_ready", cx_req_ready, 1);
    chk("t4_first_data", cx_resp_data, 32'h40);
    tick();
    cxu_resp_valid = '0;
    #1;
    chk("t4_pushpop_ready", cx_req_ready, 1);
    tick();
    cx_req_valid = 1'b0;
    #1;
    chk("t4_full_again", cx_req_ready, 0);
    cxu_resp(1, 32'h41, 4'h0);
    repeat (4) tick();
    cxu_resp_valid = '0;
    #1;
    chk("t4_drain_last", cx_resp_valid, 1);
    tick();
    chk("t4_drained", cx_resp_valid, 0);
    chk("t4_empty_ready", cx_req_ready, 1);

    // ---- timeout and late-response drop ----
    req(2'd1);
    tick();
    cx_req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < TO; k++) begin
      if (cx_resp_valid) seen = 1'b1;
      tick();
    end
    chk("t5_no_early_resp", seen, 0);
    chk("t5_to_valid", cx_resp_valid, 1);
    chk("t5_to_status", cx_resp_status, 4'h2);
    chk("t5_to_data", cx_resp_data, 0);
    chk("t5_drop_ready_idle", cxu_resp_ready, 3'b010);
    cxu_resp(1, 32'hDEAD, 4'h0);
    #1;
    chk("t5_drop_ready", cxu_resp_ready, 3'b010);
    tick();
    cxu_resp_valid = '0;
    #1;
    chk("t5_no_host_resp", cx_resp_valid, 0);
    chk("t5_drop_cleared", cxu_resp_ready, 3'b000);
    tick();
    chk("t5_still_quiet", cx_resp_valid, 0);

    // ---- backpressure ----
    cx_resp_ready = 1'b0;
    req(2'd0);
    tick();
    req(2'd2);
    tick();
    cx_req_valid = 1'b0;
    cxu_resp(0, 32'h11, 4'h3);
    #1;
    chk("t6_c0_taken", cxu_resp_ready, 3'b001);
    tick();
    cxu_resp_valid = '0;
    cxu_resp(2, 32'h22, 4'h5);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t6_hold%0d_valid", k), cx_resp_valid, 1);
      chk($sformatf("t6_hold%0d_data", k), cx_resp_data, 32'h11);
      chk($sformatf("t6_hold%0d_status", k), cx_resp_status, 4'h3);
      chk($sformatf("t6_hold%0d_c2_blocked", k), cxu_resp_ready, 3'b000);
      tick();
    end
    cx_resp_ready = 1'b1;
    #1;
    chk("t6_c2_taken", cxu_resp_ready, 3'b100);
    tick();
    cxu_resp_valid = '0;
    cx_resp_ready  = 1'b0;
    #1;
    chk("t6_second_data", cx_resp_data, 32'h22);
    chk("t6_second_status", cx_resp_status, 4'h5);

    // ---- reset with requests outstanding ----
    req(2'd1);
    tick();
    req(2'd0);
    tick();
    cx_req_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", cx_resp_valid, 0);
    chk("t7_rst_status", cx_resp_status, 0);
    chk("t7_rst_data", cx_resp_data, 0);
    cx_resp_ready = 1'b1;
    cxu_req_ready = 3'b101;
    cx_cxu_id     = 2'd1;
    #1;
    chk("t7_tgt_busy", cx_req_ready, 0);
    cx_cxu_id = 2'd0;
    #1;
    chk("t7_tgt_ready", cx_req_ready, 1);
    cxu_resp(1, 32'h99, 4'h0);
    cxu_resp(0, 32'h98, 4'h0);
    #1;
    chk("t7_no_resp_ready", cxu_resp_ready, 3'b000);
    tick();
    chk("t7_no_resp", cx_resp_valid, 0);
    cxu_resp_valid = '0;
    cxu_req_ready  = 3'b111;
    for (int k = 0; k < 4; k++) begin
      req(2'd0);
      #1;
      chk($sformatf("t7_refill%0d_ready", k), cx_req_ready, 1);
      tick();
    end
    chk("t7_refill_full", cx_req_ready, 0);
    cx_req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
